// File: rtl/rr_mux_arbiter_pkg.sv
// ============================================================================
// rr_mux_arbiter_pkg : shared FSM encoding and width helper for the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package rr_mux_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Counter width able to hold 0..max_beats inclusive
  function automatic int cnt_width(input int max_beats);
    return (max_beats < 1) ? 1 : $clog2(max_beats + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_mux_arbiter_if.sv
// ============================================================================
// rr_mux_arbiter_if : N requester valid/ready ports plus the shared sink port
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rr_mux_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last
  );

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last
  );
endinterface

`default_nettype wire

// File: rtl/rr_mux_arbiter_pick.sv
// ============================================================================
// rr_mux_arbiter_pick : rotate-priority encoder, searches upward from last+1
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_mux_arbiter_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic                 any_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int IDW = $clog2(N);

  int pos;

  // Walk from farthest to nearest so the nearest set bit is the final writer
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    pos   = 0;
    for (int k = N; k >= 1; k--) begin
      pos = (int'(last_i) + k) % N;
      if (req_i[IDW'(pos)]) begin
        any_o = 1'b1;
        idx_o = IDW'(pos);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// rr_mux_arbiter : round-robin N:1 mux arbiter with packet lock and beat cap
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BEATS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_mux_arbiter_if.slave      bus,
  output logic [$clog2(N)-1:0] grant_id_o,
  output logic                 busy_o,
  output logic                 overrun_o
);
  localparam int IDW = $clog2(N);
  localparam int CW  = cnt_width(MAX_BEATS);

  state_e         state_q;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] grant_id_q;
  logic [CW-1:0]  beat_cnt_q;
  logic [CW-1:0]  beat_cnt_d;
  logic           overrun_q;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic [W-1:0]   data_a [N];

  logic           busy;
  logic           valid_g;
  logic           last_g;
  logic           at_max;
  logic           xfer;
  logic           release_now;
  logic           force_rel;

  rr_mux_arbiter_pick #(.N(N)) u_pick (
    .req_i  (bus.req_valid),
    .last_i (last_grant_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign data_a[i] = bus.req_data[i*W +: W];
  end

  always_comb begin
    busy        = (state_q == ST_GRANT);
    valid_g     = bus.req_valid[grant_id_q];
    last_g      = bus.req_last[grant_id_q];
    at_max      = (beat_cnt_q == CW'(MAX_BEATS - 1));
    xfer        = busy && valid_g && bus.out_ready;
    release_now = xfer && (last_g || at_max);
    force_rel   = xfer && at_max && !last_g;
    beat_cnt_d  = beat_cnt_q + CW'(1);
  end

  // Datapath stays combinational from the registered select, so a beat in a
  // reset cycle is still presented to the sink
  always_comb begin
    bus.req_ready = '0;
    if (busy) begin
      bus.req_ready[grant_id_q] = bus.out_ready;
    end
    bus.out_valid = busy && valid_g;
    bus.out_data  = data_a[grant_id_q];
    bus.out_last  = busy && (last_g || at_max);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(N - 1);
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_id_q <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            last_grant_q <= grant_id_q;
            overrun_q    <= force_rel;
            state_q      <= ST_IDLE;
          end else if (xfer) begin
            beat_cnt_q <= beat_cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_id_o = grant_id_q;
  assign busy_o     = busy;
  assign overrun_o  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// ============================================================================
// tb_rr_mux_arbiter : directed vector table plus multi-cycle corner sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rr_mux_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant_id;
  logic       busy;
  logic       overrun;
  int         total = 0;
  int         bad   = 0;

  rr_mux_arbiter_if #(.N(N), .W(W)) bus ();

  rr_mux_arbiter #(.N(N), .W(W), .MAX_BEATS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .grant_id_o (grant_id),
    .busy_o     (busy),
    .overrun_o  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [3:0] l;
    logic       rdy;
    logic       busy;
    logic       ov;
    logic [1:0] gid;
    logic [3:0] rr;
    logic       olast;
    logic       ovr;
    logic [7:0] data;
  } vec_t;

  vec_t tbl [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset, then round-robin over four single-beat requesters
    tbl[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, 8'hA0};
    tbl[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b0, 8'hA1};
    tbl[6]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b0, 8'hA2};
    tbl[8]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b0, 8'hA3};
    tbl[10] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, 8'hA0};
    tbl[12] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 8'h00};

    rst           = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_last  = 4'hF;
    bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.out_ready = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      rst           = tbl[i].rst;
      bus.req_valid = tbl[i].v;
      bus.req_last  = tbl[i].l;
      bus.out_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
      chk($sformatf("row%0d grant_id", i), 32'(grant_id), 32'(tbl[i].gid));
      chk($sformatf("row%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].rr));
      chk($sformatf("row%0d out_last", i), 32'(bus.out_last), 32'(tbl[i].olast));
      chk($sformatf("row%0d overrun", i), 32'(overrun), 32'(tbl[i].ovr));
      if (tbl[i].ov) chk($sformatf("row%0d out_data", i), 32'(bus.out_data), 32'(tbl[i].data));
      tick();
    end

    // Burst lock: req0 sends 3 beats while req1 waits
    do_reset();
    bus.req_valid = 4'b0011;
    tick();
    for (int b = 1; b <= 3; b++) begin
      bus.req_last = (b == 3) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      chk($sformatf("burst b%0d req_ready", b), 32'(bus.req_ready), 32'h1);
      chk($sformatf("burst b%0d grant_id", b), 32'(grant_id), 32'h0);
      chk($sformatf("burst b%0d out_last", b), 32'(bus.out_last), (b == 3) ? 32'h1 : 32'h0);
      tick();
    end
    bus.req_last = 4'b0000;
    @(negedge clk);
    chk("burst bubble busy", 32'(busy), 32'h0);
    chk("burst bubble req_ready", 32'(bus.req_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("burst next grant_id", 32'(grant_id), 32'h1);
    chk("burst next req_ready", 32'(bus.req_ready), 32'h2);

    // Backpressure: four stalled cycles mid-packet hold data and grant
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'h10};
    tick();
    @(negedge clk);
    chk("bp beat1 req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_data[7:0] = 8'h11;
    bus.out_ready     = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk($sformatf("bp stall%0d out_data", s), 32'(bus.out_data), 32'h11);
      chk($sformatf("bp stall%0d busy", s), 32'(busy), 32'h1);
      chk($sformatf("bp stall%0d req_ready", s), 32'(bus.req_ready), 32'h0);
      tick();
    end
    // Beats 2..7 resume; beat 8 must be the forced end if the stall left beat_cnt intact
    bus.out_ready = 1'b1;
    for (int b = 2; b <= 8; b++) begin
      @(negedge clk);
      chk($sformatf("bp beat%0d out_last", b), 32'(bus.out_last), (b == 8) ? 32'h1 : 32'h0);
      tick();
    end
    @(negedge clk);
    chk("bp after busy", 32'(busy), 32'h0);
    chk("bp after overrun", 32'(overrun), 32'h1);
    tick();
    @(negedge clk);
    chk("bp single regrant busy", 32'(busy), 32'h1);
    chk("bp single regrant grant_id", 32'(grant_id), 32'h0);

    // Overrun: req2 streams without last, req3 waiting
    do_reset();
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b1100;
    for (int b = 1; b <= 8; b++) begin
      @(negedge clk);
      chk($sformatf("ovr beat%0d grant_id", b), 32'(grant_id), 32'h2);
      chk($sformatf("ovr beat%0d out_last", b), 32'(bus.out_last), (b == 8) ? 32'h1 : 32'h0);
      chk($sformatf("ovr beat%0d overrun", b), 32'(overrun), 32'h0);
      tick();
    end
    @(negedge clk);
    chk("ovr pulse", 32'(overrun), 32'h1);
    chk("ovr bubble busy", 32'(busy), 32'h0);
    tick();
    @(negedge clk);
    chk("ovr pulse end", 32'(overrun), 32'h0);
    chk("ovr next grant_id", 32'(grant_id), 32'h3);
    chk("ovr next req_ready", 32'(bus.req_ready), 32'h8);

    // Reset during beat 2 of req1's packet
    do_reset();
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0011;
    @(negedge clk);
    chk("rstmid beat1 grant_id", 32'(grant_id), 32'h1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid beat2 out_valid", 32'(bus.out_valid), 32'h1);
    chk("rstmid beat2 req_ready", 32'(bus.req_ready), 32'h2);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid after busy", 32'(busy), 32'h0);
    chk("rstmid after grant_id", 32'(grant_id), 32'h0);
    tick();
    @(negedge clk);
    chk("rstmid req0 priority grant_id", 32'(grant_id), 32'h0);
    chk("rstmid req0 priority req_ready", 32'(bus.req_ready), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
